// File: rtl/tt_fll_pkg.sv
// rtl/tt_fll_pkg.sv - shared types, control-word limits and saturation helper for the FLL controller
package tt_fll_pkg;

  typedef logic signed [15:0] ctrl_t;

  localparam ctrl_t CTRL_MAX = 16'sh7fff;
  localparam ctrl_t CTRL_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    COMPUTE,
    UPDATE
  } fll_state_t;

  function automatic ctrl_t sat_ctrl(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return CTRL_MAX;
    end else if (v < -32'sd32768) begin
      return CTRL_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/tt_edge_sync.sv
// rtl/tt_edge_sync.sv - two-flop synchroniser for the divided DCO clock with rising-edge pulse
module tt_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tt_fll_ctrl.sv
// rtl/tt_fll_ctrl.sv - FLL controller: windowed DCO edge count, PI update, lock detect
module tt_fll_ctrl
  import tt_fll_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 16,
  parameter int INT_W         = 24,
  parameter int KP_SHIFT      = 2,
  parameter int KI_SHIFT      = 4,
  parameter int LOCK_TOL      = 2,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_target,
  input  logic             i_dco_div,
  output logic             o_dco_enable,
  output ctrl_t            o_control,
  output logic             o_ctrl_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_locked
);

  localparam int TMR_W = $clog2(WINDOW_CYCLES);
  localparam int ERR_W = CNT_W + 1;
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [RUN_W-1:0]        RUN_MAX  = '1;
  localparam logic [RUN_W-1:0]        RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic signed [INT_W:0]   INT_LIM  = $signed({2'b00, {(INT_W-1){1'b1}}});
  localparam logic signed [INT_W:0]   INT_NLIM = -INT_LIM;
  localparam logic signed [ERR_W-1:0] TOL_P    = ERR_W'(LOCK_TOL);
  localparam logic signed [ERR_W-1:0] TOL_N    = -TOL_P;

  fll_state_t state_q, state_d;

  logic                    edge_rise;
  logic [TMR_W-1:0]        tmr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        target_q;
  logic signed [ERR_W-1:0] err_d, err_q;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [INT_W:0]   integ_sum;
  logic [RUN_W-1:0]        run_q, run_d;
  logic signed [31:0]      u_wide;
  logic                    hold_integ;
  logic                    in_tol;
  logic                    abort;

  tt_edge_sync u_edge_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .din   (i_dco_div),
    .rise  (edge_rise)
  );

  assign abort = (state_q != IDLE) && !i_enable;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    o_dco_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable) state_d = MEASURE;
      end
      MEASURE: begin
        o_dco_enable = 1'b1;
        if (tmr_q == TMR_LAST) state_d = COMPUTE;
      end
      COMPUTE: begin
        o_dco_enable = 1'b1;
        state_d      = UPDATE;
      end
      UPDATE: begin
        o_dco_enable = 1'b1;
        state_d      = MEASURE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Positive error means the DCO runs fast and needs a larger (slower) control word.
  always_comb begin
    err_d     = $signed({1'b0, cnt_q}) - $signed({1'b0, target_q});
    integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(err_d);
    if (integ_sum > INT_LIM) begin
      integ_d = INT_LIM[INT_W-1:0];
    end else if (integ_sum < INT_NLIM) begin
      integ_d = INT_NLIM[INT_W-1:0];
    end else begin
      integ_d = integ_sum[INT_W-1:0];
    end
    hold_integ = ((o_control == CTRL_MAX) && !err_d[ERR_W-1] && (err_d != '0)) ||
                 ((o_control == CTRL_MIN) && err_d[ERR_W-1]);
  end

  always_comb begin
    u_wide = (32'(err_q) <<< KP_SHIFT) + (32'(integ_q) >>> KI_SHIFT);
    in_tol = (err_q >= TOL_N) && (err_q <= TOL_P);
    if (!in_tol) begin
      run_d = '0;
    end else if (run_q == RUN_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmr_q        <= '0;
      cnt_q        <= '0;
      target_q     <= '0;
      err_q        <= '0;
      integ_q      <= '0;
      run_q        <= '0;
      o_control    <= '0;
      o_ctrl_valid <= 1'b0;
      o_count      <= '0;
      o_locked     <= 1'b0;
    end else if (abort) begin
      tmr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      integ_q      <= '0;
      run_q        <= '0;
      o_control    <= '0;
      o_ctrl_valid <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      o_ctrl_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable) begin
            target_q <= i_target;
            tmr_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MEASURE: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (edge_rise && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
        end
        COMPUTE: begin
          err_q <= err_d;
          if (!hold_integ) integ_q <= integ_d;
        end
        UPDATE: begin
          o_control    <= sat_ctrl(u_wide);
          o_ctrl_valid <= 1'b1;
          o_count      <= cnt_q;
          run_q        <= run_d;
          o_locked     <= (run_d >= RUN_LOCK);
          target_q     <= i_target;
          cnt_q        <= '0;
          tmr_q        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
